// File: rtl/pad_pkg.sv
// rtl/pad_pkg.sv - shared types and constants for the pad serializer
// Contents: FSM state enum, NES/SNES frame lengths, SNES button bit indices.
package pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } pad_state_t;

  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  // SNES serial order; bit 0 leaves the pad first.
  localparam int BTN_B     = 0;
  localparam int BTN_Y     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;
  localparam int BTN_A     = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_L     = 10;
  localparam int BTN_R     = 11;

endpackage

// File: rtl/pad_sync.sv
// rtl/pad_sync.sv - multi-flop synchronizer with edge pulses for one console pin
// Ports: i_clk, i_rst_n (async active-low), i_pin (async input),
//        o_level (synchronized level), o_rise / o_fall (one-cycle edge pulses).
module pad_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/pad_serializer.sv
// rtl/pad_serializer.sv - console game-pad parallel-to-serial shift register emulation
// Ports: clk, reset (async active-low), buttons (active-high, bit 0 first),
//        pad_latch / pad_clock (async console pins), turbo_mask (per-button turbo),
//        pad_data (active-low serial out), busy (frame bits still pending).
// Build option: PAD_SERIALIZER_TURBO_EN adds latch-counted turbo gating of masked buttons.
module pad_serializer #(
  parameter int NUM_BITS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TURBO_DIV   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] buttons,
  input  logic                pad_latch,
  input  logic                pad_clock,
  input  logic [NUM_BITS-1:0] turbo_mask,
  output logic                pad_data,
  output logic                busy
);
  import pad_pkg::*;

  localparam int CW = $clog2(NUM_BITS + 1);

  logic              w_latch_lvl, w_latch_rise, w_latch_fall;
  logic              w_clk_rise, w_clk_lvl_unused, w_clk_fall_unused;
  pad_state_t        r_state, w_state_nxt;
  logic [CW-1:0]     r_bit_cnt, w_cnt_nxt;
  logic [NUM_BITS-1:0] r_snapshot, w_load_val, w_shifted;

  pad_sync #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_pin   (pad_latch),
    .o_level (w_latch_lvl),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  pad_sync #(.STAGES(SYNC_STAGES)) u_sync_clock (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_pin   (pad_clock),
    .o_level (w_clk_lvl_unused),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall_unused)
  );

`ifdef PAD_SERIALIZER_TURBO_EN
  logic [7:0] r_turbo_cnt;
  logic       r_turbo_phase;

  // Phase flips on the first latch of each group of TURBO_DIV latches, so the
  // first frame after reset already reports masked buttons as pressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_turbo_cnt   <= 8'd0;
      r_turbo_phase <= 1'b0;
    end else if (w_latch_rise) begin
      if (r_turbo_cnt == 8'd0) r_turbo_phase <= ~r_turbo_phase;
      r_turbo_cnt <= (r_turbo_cnt == 8'(TURBO_DIV - 1)) ? 8'd0 : r_turbo_cnt + 8'd1;
    end
  end

  assign w_load_val = buttons & ~(turbo_mask & {NUM_BITS{~r_turbo_phase}});
`else
  logic w_turbo_mask_unused;
  assign w_turbo_mask_unused = ^turbo_mask;
  assign w_load_val          = buttons;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_snapshot <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      // Transparent parallel load for as long as the console holds latch high.
      if (w_latch_lvl) r_snapshot <= w_load_val;
    end
  end

  // Latch level overrides everything: a new latch aborts any frame in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    if (w_latch_lvl) begin
      w_state_nxt = ST_LOAD;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_LOAD: if (w_latch_fall) w_state_nxt = ST_SHIFT;
        ST_SHIFT: begin
          if (w_clk_rise) begin
            if (r_bit_cnt == CW'(NUM_BITS - 1)) begin
              w_cnt_nxt   = CW'(NUM_BITS);
              w_state_nxt = ST_DONE;
            end else begin
              w_cnt_nxt = r_bit_cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_shifted = r_snapshot >> r_bit_cnt;

  always_comb begin
    pad_data = 1'b1;
    busy     = 1'b0;
    case (r_state)
      ST_LOAD, ST_SHIFT: begin
        pad_data = ~w_shifted[0];
        busy     = 1'b1;
      end
      ST_DONE: pad_data = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pad_serializer.sv
// tb/tb_pad_serializer.sv - directed self-checking bench for pad_serializer (NES and SNES widths)
module tb_pad_serializer;
  import pad_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pad_latch = 1'b0;
  logic        pad_clock = 1'b0;
  logic [7:0]  b8 = 8'h00;
  logic [7:0]  tm8 = 8'h00;
  logic [15:0] b16 = 16'h0000;
  logic [15:0] tm16 = 16'h0000;
  logic        pd8, busy8, pd16, busy16;

  int checks = 0;
  int failures = 0;

  logic [16:0] exp_pd8, exp_busy8, exp_pd16, exp_busy16;
  logic [5:0]  exp_turbo;

  always #5 clk = ~clk;

  pad_serializer #(.NUM_BITS(8), .SYNC_STAGES(2), .TURBO_DIV(2)) dut8 (
    .clk(clk), .reset(reset), .buttons(b8), .pad_latch(pad_latch),
    .pad_clock(pad_clock), .turbo_mask(tm8), .pad_data(pd8), .busy(busy8)
  );

  pad_serializer #(.NUM_BITS(16), .SYNC_STAGES(2), .TURBO_DIV(4)) dut16 (
    .clk(clk), .reset(reset), .buttons(b16), .pad_latch(pad_latch),
    .pad_clock(pad_clock), .turbo_mask(tm16), .pad_data(pd16), .busy(busy16)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_pulse();
    pad_clock = 1'b1;
    cyc(2);
    pad_clock = 1'b0;
    cyc(2);
  endtask

  task automatic latch_pulse();
    pad_latch = 1'b1;
    cyc(4);
    pad_latch = 1'b0;
    cyc(3);
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_pd8", 32'(pd8), 32'd1);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_state8", 32'(dut8.r_state), 32'(ST_IDLE));
    reset = 1'b1;
    cyc(1);

    // Clock edges ignored in IDLE
    clk_pulse();
    chk("idle_pd8", 32'(pd8), 32'd1);
    chk("idle_busy8", 32'(busy8), 32'd0);
    chk("idle_cnt8", 32'(dut8.r_bit_cnt), 32'd0);

    // NES 0000_0101 / SNES 8001 frames, with latency check on latch rise
    b8  = 8'b0000_0101;
    b16 = 16'h8001;
    pad_latch = 1'b1;
    cyc(2);
    chk("lat_early_pd8", 32'(pd8), 32'd1);
    cyc(1);
    chk("lat_exact_pd8", 32'(pd8), 32'd0);
    chk("lat_exact_busy8", 32'(busy8), 32'd1);
    cyc(1);
    pad_latch = 1'b0;
    cyc(3);
    chk("shift_state8", 32'(dut8.r_state), 32'(ST_SHIFT));
    b8  = 8'hFA;   // must not disturb the frame in flight
    b16 = 16'h0000;
    exp_pd8    = 17'h000FA;
    exp_busy8  = 17'h000FF;
    exp_pd16   = 17'h07FFE;
    exp_busy16 = 17'h0FFFF;
    for (int k = 0; k <= 16; k++) begin
      chk($sformatf("nes_pd_k%0d", k), 32'(pd8), 32'(exp_pd8[k]));
      chk($sformatf("nes_busy_k%0d", k), 32'(busy8), 32'(exp_busy8[k]));
      chk($sformatf("snes_pd_k%0d", k), 32'(pd16), 32'(exp_pd16[k]));
      chk($sformatf("snes_busy_k%0d", k), 32'(busy16), 32'(exp_busy16[k]));
      if (k < 16) clk_pulse();
    end
    chk("nes_cnt_sat", 32'(dut8.r_bit_cnt), 32'd8);
    chk("nes_state_done", 32'(dut8.r_state), 32'(ST_DONE));
    chk("snes_cnt_sat", 32'(dut16.r_bit_cnt), 32'd16);

    // Clock pulses while latch is held high: load dominates, transparency
    b8 = 8'h05;
    pad_latch = 1'b1;
    cyc(4);
    clk_pulse();
    clk_pulse();
    chk("ldhold_pd8", 32'(pd8), 32'd0);
    chk("ldhold_cnt8", 32'(dut8.r_bit_cnt), 32'd0);
    chk("ldhold_state8", 32'(dut8.r_state), 32'(ST_LOAD));
    b8 = 8'h04;
    cyc(3);
    chk("ldtransp_pd8", 32'(pd8), 32'd1);
    pad_latch = 1'b0;
    cyc(3);

    // Re-latch after 3 bits with new buttons 8'h80
    clk_pulse();
    clk_pulse();
    clk_pulse();
    chk("abort_pre_cnt8", 32'(dut8.r_bit_cnt), 32'd3);
    chk("abort_pre_pd8", 32'(pd8), 32'd1);
    b8 = 8'h80;
    latch_pulse();
    chk("abort_cnt8", 32'(dut8.r_bit_cnt), 32'd0);
    chk("abort_bit0_pd8", 32'(pd8), 32'd1);
    for (int k = 0; k < 7; k++) clk_pulse();
    chk("abort_bit7_pd8", 32'(pd8), 32'd0);
    chk("abort_bit7_busy8", 32'(busy8), 32'd1);

    // Reset mid-frame after 5 bits
    b8 = 8'hFF;
    latch_pulse();
    for (int k = 0; k < 5; k++) clk_pulse();
    chk("midrst_pre_busy8", 32'(busy8), 32'd1);
    chk("midrst_pre_pd8", 32'(pd8), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_pd8", 32'(pd8), 32'd1);
    chk("midrst_busy8", 32'(busy8), 32'd0);
    cyc(1);
    reset = 1'b1;
    clk_pulse();
    clk_pulse();
    chk("postrst_pd8", 32'(pd8), 32'd1);
    chk("postrst_busy8", 32'(busy8), 32'd0);
    chk("postrst_state8", 32'(dut8.r_state), 32'(ST_IDLE));
    latch_pulse();
    chk("postrst_latch_pd8", 32'(pd8), 32'd0);
    chk("postrst_latch_busy8", 32'(busy8), 32'd1);

    // Turbo: button 0 held and masked, six frames after a fresh reset
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    b8  = 8'h01;
    tm8 = 8'h01;
`ifdef PAD_SERIALIZER_TURBO_EN
    exp_turbo = 6'b001100;   // frame f at bit f: 0,0,1,1,0,0
`else
    exp_turbo = 6'b000000;   // mask ignored, always pressed
`endif
    for (int f = 0; f < 6; f++) begin
      latch_pulse();
      chk($sformatf("turbo_f%0d", f), 32'(pd8), 32'(exp_turbo[f]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
